// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg : shared core constants plus retire-trace record types      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package riscv_pkg;

   localparam int XLEN        = 32;
   localparam int TRACE_SEQ_W = 16;

   typedef enum logic {
      TRC_DROP_NEW      = 1'b0,
      TRC_OVERWRITE_OLD = 1'b1
   } trace_ovf_e;

   typedef struct packed {
      logic [TRACE_SEQ_W-1:0] seq;
      logic [XLEN-1:0]        pc;
      logic [XLEN-1:0]        instr;
      logic [4:0]             rd;
      logic [XLEN-1:0]        rd_data;
      logic                   mem_wrt;
      logic [XLEN-1:0]        mem_addr;
      logic [XLEN-1:0]        mem_data;
   } trace_rec_t;

   // Record width for a non-default sequence width, usable in port ranges.
   function automatic int trace_rec_bits(input int seq_w, input int xlen);
      return seq_w + 5 * xlen + 6;
   endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_fifo : first-word fall-through FIFO with optional overwrite     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module trace_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter bit OVERWRITE = 1'b0
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic                     valid_o,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     drop_o
);

   localparam int                c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0]     c_FULL = (c_AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_level;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_ovf;
   logic w_wr;
   logic w_rd_adv;

   assign w_empty  = (r_level == '0);
   assign w_full   = (r_level == c_FULL);
   assign w_pop    = pop_i & ~w_empty;
   // A push into a full FIFO with no pop either replaces the head or is lost.
   assign w_ovf    = push_i & w_full & ~w_pop;
   assign w_wr     = push_i & (~w_ovf | OVERWRITE);
   assign w_rd_adv = w_pop | (w_ovf & OVERWRITE);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_adv)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr && !w_pop && !w_ovf)
            r_level <= r_level + 1'b1;
         else if (w_pop && !w_wr)
            r_level <= r_level - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= wdata_i;
   end

   assign valid_o = ~w_empty;
   assign rdata_o = w_empty ? '0 : r_mem[r_rd_ptr];
   assign level_o = r_level;
   assign full_o  = w_full;
   assign drop_o  = w_ovf;

endmodule
`default_nettype wire

// File: rtl/retire_trace_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | retire_trace_buffer : commit-interface trace capture with counters    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module retire_trace_buffer
   import riscv_pkg::*;
#(
   parameter int         XLEN     = riscv_pkg::XLEN,
   parameter int         DEPTH    = 16,
   parameter int         SEQ_W    = TRACE_SEQ_W,
   parameter trace_ovf_e OVF_MODE = TRC_DROP_NEW,
   parameter int         CNT_W    = 32
) (
   input  logic                                    clk_i,
   input  logic                                    rstn_i,
   input  logic                                    enable_i,
   input  logic                                    update_i,
   input  logic [XLEN-1:0]                         pc_i,
   input  logic [XLEN-1:0]                         instr_i,
   input  logic [4:0]                              reg_addr_i,
   input  logic [XLEN-1:0]                         reg_data_i,
   input  logic                                    mem_wrt_i,
   input  logic [XLEN-1:0]                         mem_addr_i,
   input  logic [XLEN-1:0]                         mem_data_i,
   input  logic                                    stall_i,
   output logic                                    trace_valid_o,
   input  logic                                    trace_ready_i,
   output logic [trace_rec_bits(SEQ_W, XLEN)-1:0]  trace_rec_o,
   output logic [$clog2(DEPTH):0]                  level_o,
   output logic                                    full_o,
   output logic [CNT_W-1:0]                        dropped_o,
   output logic [63:0]                             retired_o,
   output logic [CNT_W-1:0]                        stall_cnt_o
);

   typedef struct packed {
      logic [SEQ_W-1:0] seq;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  instr;
      logic [4:0]       rd;
      logic [XLEN-1:0]  rd_data;
      logic             mem_wrt;
      logic [XLEN-1:0]  mem_addr;
      logic [XLEN-1:0]  mem_data;
   } rec_t;

   logic             r_update_q;
   logic [SEQ_W-1:0] r_seq;
   logic [63:0]      r_retired;
   logic [CNT_W-1:0] r_dropped;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_event;
   logic w_drop;
   rec_t w_rec;

   assign w_event = update_i & ~r_update_q & enable_i;

   // Unused register and store fields are zeroed so records compare cleanly.
   always_comb begin
      w_rec          = '0;
      w_rec.seq      = r_seq;
      w_rec.pc       = pc_i;
      w_rec.instr    = instr_i;
      w_rec.rd       = reg_addr_i;
      w_rec.rd_data  = (reg_addr_i == 5'd0) ? '0 : reg_data_i;
      w_rec.mem_wrt  = mem_wrt_i;
      w_rec.mem_addr = mem_wrt_i ? mem_addr_i : '0;
      w_rec.mem_data = mem_wrt_i ? mem_data_i : '0;
   end

   trace_fifo #(
      .WIDTH     ($bits(rec_t)),
      .DEPTH     (DEPTH),
      .OVERWRITE (OVF_MODE == TRC_OVERWRITE_OLD)
   ) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (w_event),
      .pop_i   (trace_ready_i),
      .wdata_i (w_rec),
      .valid_o (trace_valid_o),
      .rdata_o (trace_rec_o),
      .level_o (level_o),
      .full_o  (full_o),
      .drop_o  (w_drop)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_update_q  <= 1'b0;
         r_seq       <= '0;
         r_retired   <= '0;
         r_dropped   <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_update_q <= update_i;
         if (w_event) begin
            r_seq     <= r_seq + 1'b1;
            r_retired <= r_retired + 64'd1;
         end
         if (w_drop && (r_dropped != '1))
            r_dropped <= r_dropped + 1'b1;
         if (stall_i && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign dropped_o   = r_dropped;
   assign retired_o   = r_retired;
   assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire
